// File: rtl/ro_bus_demux.sv
`default_nettype none
// ============================================================================
// Module      : ro_bus_demux
// Description : Receive-side demultiplexer for the shared readout bus. Tracks
//               the cores' gray-counter drive schedule with a local binary
//               counter, captures the owning core's even/polarity bits each
//               slot, keeps per-core holding registers and presents a
//               single-entry valid/ready event stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_bus_demux #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 19,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bus_eve,
    input  logic            bus_pol_eve,
    input  logic            ev_ready,
    output logic            ev_valid,
    output logic [CH_W-1:0] ev_ch,
    output logic            ev_eve,
    output logic            ev_pol,
    output logic [N_CH-1:0] ch_eve,
    output logic [N_CH-1:0] ch_pol_eve,
    output logic            frame_tick,
    output logic            overflow
);

    localparam logic [CH_W-1:0] c_last_ch = CH_W'(N_CH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt;
    logic             w_cap;
    logic [CH_W-1:0]  w_ch;

    logic             r_ev_valid;
    logic [CH_W-1:0]  r_ev_ch;
    logic             r_ev_eve;
    logic             r_ev_pol;
    logic [N_CH-1:0]  r_ch_eve;
    logic [N_CH-1:0]  r_ch_pol_eve;
    logic             r_frame_tick;
    logic             r_overflow;

    // Slot decode: the slot is the trailing-zero count of cnt+1. A core owns
    // the slot only when that count is below N_CH, i.e. when any of the low
    // N_CH bits of cnt+1 is set; the lowest set bit is then the channel.
    always_comb begin
        w_nxt = r_cnt + CNT_W'(1);
        w_cap = |w_nxt[N_CH-1:0];
        w_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_nxt[i]) begin
                w_ch = CH_W'(i);
            end
        end
    end

    // Free-running schedule counter, mirrors the cores' gray counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

    // Capture, per-channel holding registers, event register and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ev_valid   <= 1'b0;
            r_ev_ch      <= '0;
            r_ev_eve     <= 1'b0;
            r_ev_pol     <= 1'b0;
            r_ch_eve     <= '0;
            r_ch_pol_eve <= '0;
            r_frame_tick <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_tick <= w_cap && (w_ch == c_last_ch);
            if (w_cap) begin
                r_ch_eve[w_ch]     <= bus_eve;
                r_ch_pol_eve[w_ch] <= bus_pol_eve;
                if (!r_ev_valid || ev_ready) begin
                    // Slot free, or the old event leaves this same cycle.
                    r_ev_valid <= 1'b1;
                    r_ev_ch    <= w_ch;
                    r_ev_eve   <= bus_eve;
                    r_ev_pol   <= bus_pol_eve;
                end else begin
                    // Held event is not consumed: drop the new one.
                    r_overflow <= 1'b1;
                end
            end else if (r_ev_valid && ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign ev_valid   = r_ev_valid;
    assign ev_ch      = r_ev_ch;
    assign ev_eve     = r_ev_eve;
    assign ev_pol     = r_ev_pol;
    assign ch_eve     = r_ch_eve;
    assign ch_pol_eve = r_ch_pol_eve;
    assign frame_tick = r_frame_tick;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ro_bus_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_bus_demux
// Description : Directed self-checking bench for ro_bus_demux. A default
//               instance (N_CH=8, CNT_W=19) and a small instance (N_CH=4,
//               CNT_W=6) share the clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_bus_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default-parameter instance
    logic       rst_a = 1'b1;
    logic       eve_a = 1'b0;
    logic       pol_a = 1'b0;
    logic       rdy_a = 1'b1;
    logic       v_a;
    logic [2:0] ch_a;
    logic       ee_a;
    logic       ep_a;
    logic [7:0] ce_a;
    logic [7:0] cp_a;
    logic       ft_a;
    logic       ov_a;

    ro_bus_demux dut (
        .clk        (clk),
        .reset      (rst_a),
        .bus_eve    (eve_a),
        .bus_pol_eve(pol_a),
        .ev_ready   (rdy_a),
        .ev_valid   (v_a),
        .ev_ch      (ch_a),
        .ev_eve     (ee_a),
        .ev_pol     (ep_a),
        .ch_eve     (ce_a),
        .ch_pol_eve (cp_a),
        .frame_tick (ft_a),
        .overflow   (ov_a)
    );

    // Small instance for frame_tick and counter wrap
    logic       rst_b = 1'b1;
    logic       eve_b = 1'b0;
    logic       pol_b = 1'b0;
    logic       rdy_b = 1'b1;
    logic       v_b;
    logic [1:0] ch_b;
    logic       ee_b;
    logic       ep_b;
    logic [3:0] ce_b;
    logic [3:0] cp_b;
    logic       ft_b;
    logic       ov_b;

    ro_bus_demux #(.N_CH(4), .CNT_W(6)) dut_s (
        .clk        (clk),
        .reset      (rst_b),
        .bus_eve    (eve_b),
        .bus_pol_eve(pol_b),
        .ev_ready   (rdy_b),
        .ev_valid   (v_b),
        .ev_ch      (ch_b),
        .ev_eve     (ee_b),
        .ev_pol     (ep_b),
        .ch_eve     (ce_b),
        .ch_pol_eve (cp_b),
        .frame_tick (ft_b),
        .overflow   (ov_b)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles; the next edge after release handles cnt = 0.
    task automatic reset_a();
        rst_a = 1'b1;
        step();
        step();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_a();
        checks++;
        if ({v_a, ch_a, ee_a, ep_a, ce_a, cp_a, ft_a, ov_a} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {v_a, ch_a, ee_a, ep_a, ce_a, cp_a, ft_a, ov_a});
        end
    endtask

    task automatic test_slot_sequence();
        logic [2:0] exp_ch [8] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd3};
        logic [7:0] exp_ce [8] = '{8'h01, 8'h03, 8'h03, 8'h07, 8'h07, 8'h07, 8'h07, 8'h0F};
        reset_a();
        rdy_a = 1'b1;
        eve_a = 1'b1;
        pol_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (v_a !== 1'b1 || ch_a !== exp_ch[k] || ee_a !== 1'b1) begin
                errors++;
                $display("FAIL seq_event[%0d]: got v=%b ch=%0d eve=%b required v=1 ch=%0d eve=1",
                         k, v_a, ch_a, ee_a, exp_ch[k]);
            end
            checks++;
            if (ce_a !== exp_ce[k] || cp_a !== 8'h00 || ft_a !== 1'b0) begin
                errors++;
                $display("FAIL seq_chregs[%0d]: got ch_eve=%h ch_pol=%h ft=%b required %h 00 0",
                         k, ce_a, cp_a, ft_a, exp_ce[k]);
            end
        end
        checks++;
        if (ov_a !== 1'b0) begin
            errors++;
            $display("FAIL seq_no_overflow: got %b required 0", ov_a);
        end
    endtask

    // Capture and handshake every cycle with changing payload.
    task automatic test_back_to_back();
        logic [7:0] eve_pat = 8'b1010_1010; // bit k = eve at edge k
        logic [7:0] pol_pat = 8'b1100_1100; // bit k = pol at edge k
        reset_a();
        rdy_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            eve_a = eve_pat[k];
            pol_a = pol_pat[k];
            step();
            checks++;
            if (v_a !== 1'b1 || ee_a !== eve_pat[k] || ep_a !== pol_pat[k] || ov_a !== 1'b0) begin
                errors++;
                $display("FAIL b2b_payload[%0d]: got v=%b eve=%b pol=%b ov=%b required 1 %b %b 0",
                         k, v_a, ee_a, ep_a, ov_a, eve_pat[k], pol_pat[k]);
            end
        end
        checks++;
        if (ce_a !== 8'h0E || cp_a !== 8'h0D) begin
            errors++;
            $display("FAIL b2b_chregs: got ch_eve=%h ch_pol=%h required 0e 0d", ce_a, cp_a);
        end
    endtask

    task automatic test_backpressure();
        reset_a();
        rdy_a = 1'b0;
        eve_a = 1'b1;
        pol_a = 1'b1;
        step(); // slot 0 loaded
        checks++;
        if (v_a !== 1'b1 || ch_a !== 3'd0 || ov_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got v=%b ch=%0d ov=%b required 1 0 0", v_a, ch_a, ov_a);
        end
        eve_a = 1'b0;
        pol_a = 1'b0;
        step(); // slot 1 dropped
        checks++;
        if (v_a !== 1'b1 || ch_a !== 3'd0 || ee_a !== 1'b1 || ep_a !== 1'b1 || ov_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got v=%b ch=%0d eve=%b pol=%b ov=%b required 1 0 1 1 1",
                     v_a, ch_a, ee_a, ep_a, ov_a);
        end
        checks++;
        if (ce_a !== 8'h01 || cp_a !== 8'h01) begin
            errors++;
            $display("FAIL bp_chregs: got ch_eve=%h ch_pol=%h required 01 01", ce_a, cp_a);
        end
        step(); // slot 0 dropped
        rdy_a = 1'b1;
        step(); // slot 2 loaded while old event leaves
        checks++;
        if (v_a !== 1'b1 || ch_a !== 3'd2 || ee_a !== 1'b0 || ov_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%b ch=%0d eve=%b ov=%b required 1 2 0 1",
                     v_a, ch_a, ee_a, ov_a);
        end
        step(); // slot 0
        checks++;
        if (v_a !== 1'b1 || ch_a !== 3'd0 || ov_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_flow: got v=%b ch=%0d ov=%b required 1 0 1", v_a, ch_a, ov_a);
        end
    endtask

    // Channel-3 frame ticks and counter wrap on the small instance.
    task automatic test_frame_wrap();
        rst_b = 1'b1;
        step();
        step();
        rst_b = 1'b0;
        rdy_b = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            eve_b = (((k - 1) % 16) == 7);
            step();
            case (k)
                8, 24, 40, 56: begin
                    checks++;
                    if (ft_b !== 1'b1 || ch_b !== 2'd3 || ee_b !== 1'b1) begin
                        errors++;
                        $display("FAIL frame_tick_hi[%0d]: got ft=%b ch=%0d eve=%b required 1 3 1",
                                 k, ft_b, ch_b, ee_b);
                    end
                end
                9, 16, 32: begin
                    checks++;
                    if (ft_b !== 1'b0) begin
                        errors++;
                        $display("FAIL frame_tick_lo[%0d]: got %b required 0", k, ft_b);
                    end
                end
                16, 64, 128: ;
                default: ;
            endcase
            if (k == 16 || k == 64 || k == 128) begin
                checks++;
                if (v_b !== 1'b0) begin
                    errors++;
                    $display("FAIL no_capture[%0d]: got ev_valid=%b required 0", k, v_b);
                end
            end
            if (k == 65 || k == 129) begin
                checks++;
                if (v_b !== 1'b1 || ch_b !== 2'd0) begin
                    errors++;
                    $display("FAIL wrap_resume[%0d]: got v=%b ch=%0d required 1 0", k, v_b, ch_b);
                end
            end
        end
        checks++;
        if (ce_b !== 4'b1000 || ov_b !== 1'b0) begin
            errors++;
            $display("FAIL small_chregs: got ch_eve=%b ov=%b required 1000 0", ce_b, ov_b);
        end
    endtask

    task automatic test_midrun_reset();
        logic [2:0] exp_ch [4] = '{3'd0, 3'd1, 3'd0, 3'd2};
        reset_a();
        rdy_a = 1'b0;
        eve_a = 1'b1;
        pol_a = 1'b1;
        for (int k = 0; k < 36; k++) step();
        checks++;
        if (v_a !== 1'b1 || ov_a !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: got v=%b ov=%b required 1 1", v_a, ov_a);
        end
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        checks++;
        if ({v_a, ch_a, ee_a, ep_a, ce_a, cp_a, ft_a, ov_a} !== 23'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %b required all zero",
                     {v_a, ch_a, ee_a, ep_a, ce_a, cp_a, ft_a, ov_a});
        end
        rdy_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (v_a !== 1'b1 || ch_a !== exp_ch[k] || ov_a !== 1'b0) begin
                errors++;
                $display("FAIL midrun_restart[%0d]: got v=%b ch=%0d ov=%b required 1 %0d 0",
                         k, v_a, ch_a, ov_a, exp_ch[k]);
            end
        end
    endtask

    initial begin
        step();
        test_reset();
        test_slot_sequence();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_frame_wrap();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
